// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and its instruction memory.
//   imem_addr  : word-aligned fetch address (driven by the fetch stage)
//   imem_rdata : instruction word for imem_addr (driven by the memory)
//   imem_ready : imem_rdata is valid this cycle (driven by the memory)
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address, and captures
// {instruction, PC, PC+4} into IF/ID. It honours the load-use stall controls
// from hazard detection and the branch/jump redirect from Execute. It inserts
// NOP bubbles on a redirect or while instruction memory is not ready.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   PCWrite         : 1 = PC may advance, 0 = freeze PC and IF/ID
//   IF_ID_Write     : 1 = IF/ID may update, 0 = hold IF/ID (and PC)
//   PCSrc_e         : taken branch/jump resolved in Execute
//   PCTarget_e      : redirect target (low two bits ignored)
//   imem            : instruction-memory bus (master side)
//   Instr_d, PC_d, PCPlus4_d, Valid_d : IF/ID register contents
//   Raddr1_d, Raddr2_d : rs1/rs2 fields of Instr_d, fed back to hazard detection
//   StallCount      : saturating count of PCWrite=0 cycles (not counting redirects)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              IF_ID_Write,
    input  logic              PCSrc_e,
    input  logic [31:0]       PCTarget_e,
    fetch_stage_if.master     imem,
    output logic [31:0]       Instr_d,
    output logic [31:0]       PC_d,
    output logic [31:0]       PCPlus4_d,
    output logic              Valid_d,
    output logic [4:0]        Raddr1_d,
    output logic [4:0]        Raddr2_d,
    output logic [CNT_W-1:0]  StallCount
);

    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      instr_reg, instr_next;
    logic [31:0]      pc_d_reg, pc_d_next;
    logic [31:0]      pc4_d_reg, pc4_d_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] stall_reg, stall_next;
    logic [31:0]      pc_plus4;

    // Target is always word aligned; the byte-offset bits are dropped.
    logic unused_target_bits;
    assign unused_target_bits = ^PCTarget_e[1:0];

    assign pc_plus4 = pc_reg + 32'd4;

    always_comb begin
        pc_next    = pc_reg;
        instr_next = instr_reg;
        pc_d_next  = pc_d_reg;
        pc4_d_next = pc4_d_reg;
        valid_next = valid_reg;

        if (PCSrc_e) begin
            // The instruction in Decode is on the wrong path: squash it,
            // regardless of stall controls or memory readiness.
            pc_next    = {PCTarget_e[31:2], 2'b00};
            instr_next = NOP_INSTR;
            pc_d_next  = 32'd0;
            pc4_d_next = 32'd0;
            valid_next = 1'b0;
        end else if (!PCWrite) begin
            // Load-use stall: a frozen PC always freezes IF/ID too,
            // otherwise the instruction in Decode would be duplicated.
        end else if (!imem.imem_ready) begin
            if (IF_ID_Write) begin
                instr_next = NOP_INSTR;
                pc_d_next  = 32'd0;
                pc4_d_next = 32'd0;
                valid_next = 1'b0;
            end
        end else if (IF_ID_Write) begin
            // The PC only advances when the fetched word is actually
            // captured, so nothing is lost while IF/ID is held.
            pc_next    = pc_plus4;
            instr_next = imem.imem_rdata;
            pc_d_next  = pc_reg;
            pc4_d_next = pc_plus4;
            valid_next = 1'b1;
        end
    end

    always_comb begin
        stall_next = stall_reg;
        if (!PCSrc_e && !PCWrite && (stall_reg != {CNT_W{1'b1}}))
            stall_next = stall_reg + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            instr_reg <= NOP_INSTR;
            pc_d_reg  <= 32'd0;
            pc4_d_reg <= 32'd0;
            valid_reg <= 1'b0;
            stall_reg <= '0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            pc_d_reg  <= pc_d_next;
            pc4_d_reg <= pc4_d_next;
            valid_reg <= valid_next;
            stall_reg <= stall_next;
        end
    end

    assign imem.imem_addr = pc_reg;
    assign Instr_d        = instr_reg;
    assign PC_d           = pc_d_reg;
    assign PCPlus4_d      = pc4_d_reg;
    assign Valid_d        = valid_reg;
    assign Raddr1_d       = instr_reg[19:15];
    assign Raddr2_d       = instr_reg[24:20];
    assign StallCount     = stall_reg;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcw, ifidw, pcsrc, rdy;
    logic [31:0] tgt;
    logic [31:0] instr_d, pc_d, pc4_d;
    logic        valid_d;
    logic [4:0]  ra1, ra2;
    logic [15:0] stall_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage_if imem_bus ();

    // Address-tagged memory; garbage when not ready so a wrong sample shows.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    assign imem_bus.imem_ready = rdy;
    assign imem_bus.imem_rdata = rdy ? mem_word(imem_bus.imem_addr) : 32'hDEAD_BEEF;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP),
        .CNT_W     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .PCWrite     (pcw),
        .IF_ID_Write (ifidw),
        .PCSrc_e     (pcsrc),
        .PCTarget_e  (tgt),
        .imem        (imem_bus.master),
        .Instr_d     (instr_d),
        .PC_d        (pc_d),
        .PCPlus4_d   (pc4_d),
        .Valid_d     (valid_d),
        .Raddr1_d    (ra1),
        .Raddr2_d    (ra2),
        .StallCount  (stall_cnt)
    );

    typedef struct {
        logic        pcw, ifidw, pcsrc;
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] e_pc, e_pcd;
        logic        e_v;
        logic [15:0] e_stall;
    } vec_t;

    typedef struct {
        logic [31:0] pc, instr, pcd, pc4;
        logic        v;
        logic [15:0] stall;
    } exp_t;

    vec_t tbl[21];
    exp_t exp_q[$];

    function automatic vec_t mk(input logic w, input logic iw, input logic s,
                                input logic [31:0] t, input logic r,
                                input logic [31:0] epc, input logic [31:0] epcd,
                                input logic ev, input logic [15:0] est);
        vec_t v;
        v.pcw = w; v.ifidw = iw; v.pcsrc = s; v.tgt = t; v.rdy = r;
        v.e_pc = epc; v.e_pcd = epcd; v.e_v = ev; v.e_stall = est;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, " imem_addr"}, imem_bus.imem_addr, e.pc);
        check({tag, " Instr_d"}, instr_d, e.instr);
        check({tag, " PC_d"}, pc_d, e.pcd);
        check({tag, " PCPlus4_d"}, pc4_d, e.pc4);
        check({tag, " Valid_d"}, {31'd0, valid_d}, {31'd0, e.v});
        check({tag, " Raddr1_d"}, {27'd0, ra1}, {27'd0, e.instr[19:15]});
        check({tag, " Raddr2_d"}, {27'd0, ra2}, {27'd0, e.instr[24:20]});
        check({tag, " StallCount"}, {16'd0, stall_cnt}, {16'd0, e.stall});
    endtask

    function automatic exp_t mk_exp(input logic [31:0] epc, input logic [31:0] epcd,
                                    input logic ev, input logic [15:0] est);
        exp_t e;
        e.pc    = epc;
        e.pcd   = epcd;
        e.v     = ev;
        e.instr = ev ? mem_word(epcd) : NOP;
        e.pc4   = ev ? epcd + 32'd4 : 32'd0;
        e.stall = est;
        return e;
    endfunction

    task automatic drive(input logic w, input logic iw, input logic s,
                         input logic [31:0] t, input logic r);
        pcw = w; ifidw = iw; pcsrc = s; tgt = t; rdy = r;
    endtask

    initial begin
        exp_t e;

        //          pcw ifw src target        rdy  exp_pc         exp_pc_d       v  stall
        tbl[0]  = mk(1, 1, 0, 32'h0,          1,   32'h4,         32'h0,         1, 0);
        tbl[1]  = mk(1, 1, 0, 32'h0,          1,   32'h8,         32'h4,         1, 0);
        tbl[2]  = mk(1, 1, 0, 32'h0,          1,   32'hC,         32'h8,         1, 0);
        tbl[3]  = mk(1, 1, 0, 32'h0,          1,   32'h10,        32'hC,         1, 0);
        tbl[4]  = mk(0, 0, 0, 32'h0,          1,   32'h10,        32'hC,         1, 1);
        tbl[5]  = mk(1, 1, 0, 32'h0,          1,   32'h14,        32'h10,        1, 1);
        tbl[6]  = mk(1, 1, 0, 32'h0,          1,   32'h18,        32'h14,        1, 1);
        tbl[7]  = mk(0, 1, 0, 32'h0,          1,   32'h18,        32'h14,        1, 2);
        tbl[8]  = mk(0, 1, 1, 32'h203,        1,   32'h200,       32'h0,         0, 2);
        tbl[9]  = mk(1, 1, 0, 32'h0,          1,   32'h204,       32'h200,       1, 2);
        tbl[10] = mk(1, 1, 1, 32'h40,         0,   32'h40,        32'h0,         0, 2);
        tbl[11] = mk(1, 1, 0, 32'h0,          0,   32'h40,        32'h0,         0, 2);
        tbl[12] = mk(1, 1, 0, 32'h0,          0,   32'h40,        32'h0,         0, 2);
        tbl[13] = mk(1, 1, 0, 32'h0,          0,   32'h40,        32'h0,         0, 2);
        tbl[14] = mk(1, 1, 0, 32'h0,          1,   32'h44,        32'h40,        1, 2);
        tbl[15] = mk(1, 0, 0, 32'h0,          0,   32'h44,        32'h40,        1, 2);
        tbl[16] = mk(1, 0, 0, 32'h0,          1,   32'h44,        32'h40,        1, 2);
        tbl[17] = mk(1, 1, 0, 32'h0,          1,   32'h48,        32'h44,        1, 2);
        tbl[18] = mk(1, 0, 1, 32'hFFFF_FFFE,  1,   32'hFFFF_FFFC, 32'h0,         0, 2);
        tbl[19] = mk(1, 1, 0, 32'h0,          1,   32'h0,         32'hFFFF_FFFC, 1, 2);
        tbl[20] = mk(1, 1, 0, 32'h0,          1,   32'h4,         32'h0,         1, 2);

        rst = 1'b1;
        drive(1, 1, 0, 32'h0, 1);
        @(posedge clk); #1;
        check_all("reset", mk_exp(32'h0, 32'h0, 0, 0));
        rst = 1'b0;

        // Table vectors through the scoreboard
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].pcw, tbl[i].ifidw, tbl[i].pcsrc, tbl[i].tgt, tbl[i].rdy);
            exp_q.push_back(mk_exp(tbl[i].e_pc, tbl[i].e_pcd, tbl[i].e_v, tbl[i].e_stall));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            $display("vec %0d: pcw=%b ifidw=%b pcsrc=%b rdy=%b -> pc=%h pc_d=%h v=%b stall=%0d",
                     i, pcw, ifidw, pcsrc, rdy, imem_bus.imem_addr, pc_d, valid_d, stall_cnt);
            check_all($sformatf("vec%0d", i), e);
        end

        // Saturating stall counter: starts at 2, long PCWrite=0 run
        drive(0, 1, 0, 32'h0, 1);
        for (int i = 0; i < 65532; i++) @(posedge clk);
        #1;
        check("sat pre", {16'd0, stall_cnt}, 32'h0000_FFFE);
        @(posedge clk); #1;
        check("sat hit", {16'd0, stall_cnt}, 32'h0000_FFFF);
        for (int i = 0; i < 10; i++) @(posedge clk);
        #1;
        check("sat hold", {16'd0, stall_cnt}, 32'h0000_FFFF);
        check("sat pc hold", imem_bus.imem_addr, 32'h4);
        $display("saturation: stall=%h pc=%h", stall_cnt, imem_bus.imem_addr);

        // Asynchronous reset mid-stall with a redirect pending
        drive(0, 1, 1, 32'h300, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all("async rst", mk_exp(32'h0, 32'h0, 0, 0));
        @(posedge clk); #1;
        check_all("rst held", mk_exp(32'h0, 32'h0, 0, 0));
        rst = 1'b0;
        drive(1, 1, 0, 32'h0, 1);
        @(posedge clk); #1;
        check_all("restart0", mk_exp(32'h4, 32'h0, 1, 0));
        @(posedge clk); #1;
        check_all("restart1", mk_exp(32'h8, 32'h4, 1, 0));
        $display("restart: pc=%h pc_d=%h v=%b", imem_bus.imem_addr, pc_d, valid_d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register that consume the load-use stall controls (PCWrite, IF_ID_Write) produced by hazard detection, plus the branch/jump redirect from Execute.
- Holds the PC and drives the instruction-memory address.
- Captures fetched instruction, PC and PC+4 into IF/ID.
- Exports Raddr1_d/Raddr2_d back to hazard detection.
- Inserts NOP bubbles on redirect or on an instruction-memory wait.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, encoding written into IF/ID when bubbling (addi x0,x0,0)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
PCWrite  input  1  1 = PC may advance; 0 = freeze PC (load-use stall)
IF_ID_Write  input  1  1 = IF/ID may update; 0 = hold IF/ID
PCSrc_e  input  1  1 = taken branch/jump resolved in Execute
PCTarget_e  input  32  redirect target from Execute
imem_addr  output  32  instruction address; equals PC_f, combinational
imem_rdata  input  32  instruction word for imem_addr
imem_ready  input  1  1 = imem_rdata valid this cycle
Instr_d  output  32  IF/ID instruction
PC_d  output  32  IF/ID PC
PCPlus4_d  output  32  IF/ID PC+4
Valid_d  output  1  IF/ID holds a real instruction
Raddr1_d  output  5  Instr_d[19:15], combinational
Raddr2_d  output  5  Instr_d[24:20], combinational
StallCount  output  CNT_W  cycles with PCWrite=0, saturating

Behaviour:
Reset (asynchronous, takes effect immediately, including mid-operation):
- PC_f=RESET_PC, Instr_d=NOP_INSTR, PC_d=0, PCPlus4_d=0, Valid_d=0, StallCount=0.

Arithmetic:
- PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- PCTarget_e[1:0] is ignored; the loaded PC is {PCTarget_e[31:2],2'b00}.

Per-cycle priority, highest first, one case applies per edge:
- 1 REDIRECT (PCSrc_e=1): PC_f<=target. IF/ID<=bubble (Instr_d=NOP_INSTR, Valid_d=0, PC_d/PCPlus4_d=0). Overrides PCWrite=0, IF_ID_Write=0 and imem_ready=0, because the Decode instruction is squashed.
- 2 STALL (PCWrite=0): PC_f holds. IF/ID holds if IF_ID_Write=0. If IF_ID_Write=1, IF/ID still holds; a PC freeze always freezes IF/ID.
- 3 IMEM WAIT (imem_ready=0): PC_f holds. IF/ID<=bubble if IF_ID_Write=1, else holds.
- 4 NORMAL: PC_f<=PC_f+4. If IF_ID_Write=1, IF/ID<={imem_rdata, PC_f, PC_f+4} with Valid_d=1. If IF_ID_Write=0, IF/ID holds and PC_f also holds, so no instruction is lost.

Latency and counters:
- Fetch-to-decode latency is 1 cycle.
- Redirect-to-first-valid-Decode latency is 2 cycles (bubble cycle, then target instruction).
- StallCount increments on every edge with PCWrite=0 and PCSrc_e=0. It saturates at all-ones and does not wrap.

Boundary conditions:
- A bubble's Raddr1_d=Raddr2_d=0, so hazard detection never stalls on a bubble.
- imem_rdata is sampled only when imem_ready=1 in NORMAL.
- PCSrc_e and imem_ready=0 in the same cycle: redirect wins. The pending fetch is abandoned; the target is fetched next cycle.

Test Plan:
- Reset release, imem_ready=1, imem returns addr-tagged words -> imem_addr 0,4,8,... each cycle; Instr_d tracks with 1-cycle lag; Valid_d=1 from 2nd edge; Raddr fields match Instr_d.
- PCWrite=0, IF_ID_Write=0 for 1 cycle at PC_f=0x10 -> PC_f stays 0x10; Instr_d/PC_d unchanged; StallCount=1; next cycle fetch resumes at 0x10 then 0x14.
- PCSrc_e=1, PCTarget_e=0x203 while PCWrite=0 -> PC_f=0x200; Instr_d=0x13, Valid_d=0; next edge Instr_d=mem[0x200], Valid_d=1; StallCount unchanged.
- imem_ready low 3 cycles at PC_f=0x40 -> PC_f holds 0x40; 3 bubbles (Valid_d=0, Instr_d=0x13); then Instr_d=mem[0x40].
- Start from PC_f=0xFFFF_FFFC, normal fetch -> PCPlus4_d=0, PC_f wraps to 0; hold PCWrite=0 for 2^CNT_W+5 cycles -> StallCount saturates at 0xFFFF.
- Assert rst mid-stall with pending redirect -> outputs take reset values immediately (async); after release fetch restarts at RESET_PC.
